// File: rtl/cordic_pkg.sv
// Constants and types shared by the CORDIC pipeline and its result collector.
package cordic_pkg;

   localparam int unsigned CORDIC_WIDTH = 16;
   localparam int unsigned CORDIC_DEPTH = 360;

   typedef enum logic [0:0] {
      COLL_IDLE    = 1'b0,
      COLL_CAPTURE = 1'b1
   } coll_state_t;

endpackage

// File: rtl/cordic_sample_fifo.sv
// Circular buffer for CORDIC samples; DEPTH need not be a power of two.
module cordic_sample_fifo #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 360
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [DW-1:0]                wr_data,
   input  logic                         rd_en,
   output logic [DW-1:0]                rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [DW-1:0]    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   // Fullness comes from the registered count, so a same-cycle read never frees a slot.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
         if (rd_ok)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
         if (wr_ok && !rd_ok)
            count <= count + CNT_W'(1);
         else if (rd_ok && !wr_ok)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/cordic_result_collector.sv
// Captures CORDIC output beats into a buffer, delimits frames on valid gaps,
// reports frame length and flags dropped beats.
module cordic_result_collector
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH = CORDIC_WIDTH,
   parameter int unsigned DEPTH = CORDIC_DEPTH,
   parameter int unsigned LEN_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic [WIDTH-1:0]             cos_in,
   input  logic [WIDTH-1:0]             sin_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_cos,
   output logic [WIDTH-1:0]             out_sin,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   input  logic                         clr_ovf,
   output logic                         frame_done,
   output logic [LEN_W-1:0]             frame_len
);

   logic [2*WIDTH-1:0] rd_data;
   logic               full;
   logic               empty;
   coll_state_t        state;
   logic [LEN_W-1:0]   len_cnt;

   cordic_sample_fifo #(
      .DW    (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (valid_in),
      .wr_data ({sin_in, cos_in}),
      .rd_en   (out_ready),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   assign out_valid = !empty;
   assign out_cos   = rd_data[WIDTH-1:0];
   assign out_sin   = rd_data[2*WIDTH-1:WIDTH];

   // A drop in the same cycle as clr_ovf wins, so no drop goes unreported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (valid_in && full)
         overflow <= 1'b1;
      else if (clr_ovf)
         overflow <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= COLL_IDLE;
         len_cnt    <= '0;
         frame_len  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            COLL_IDLE: begin
               if (valid_in) begin
                  state   <= COLL_CAPTURE;
                  len_cnt <= LEN_W'(1);
               end
            end
            COLL_CAPTURE: begin
               if (valid_in) begin
                  if (len_cnt != '1)
                     len_cnt <= len_cnt + LEN_W'(1);
               end else begin
                  state      <= COLL_IDLE;
                  frame_len  <= len_cnt;
                  frame_done <= 1'b1;
               end
            end
            default: state <= COLL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_result_collector.sv
// Randomized self-checking bench for cordic_result_collector against a queue-based model.
module tb_cordic_result_collector;

   localparam int W  = 16;
   localparam int D  = 7;
   localparam int LW = 5;
   localparam int CW = $clog2(D+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_in;
   logic [W-1:0]  cos_in;
   logic [W-1:0]  sin_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_cos;
   logic [W-1:0]  out_sin;
   logic [CW-1:0] count;
   logic          overflow;
   logic          clr_ovf;
   logic          frame_done;
   logic [LW-1:0] frame_len;

   always #5 clk = ~clk;

   cordic_result_collector #(
      .WIDTH (W),
      .DEPTH (D),
      .LEN_W (LW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .cos_in     (cos_in),
      .sin_in     (sin_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_cos    (out_cos),
      .out_sin    (out_sin),
      .count      (count),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf),
      .frame_done (frame_done),
      .frame_len  (frame_len)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a FIFO of {sin,cos}, a run-length counter and a sticky flag.
   logic [2*W-1:0] q [$];
   bit             m_ovf   = 0;
   bit             m_frame = 0;
   bit             m_done  = 0;
   int             m_run   = 0;
   int             m_len   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [2*W-1:0] head;
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("count", 64'(count), 64'(q.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("frame_done", 64'(frame_done), 64'(m_done));
      check("frame_len", 64'(frame_len), 64'(m_len));
      if (q.size() != 0) begin
         head = q[0];
         check("out_cos", 64'(out_cos), 64'(head[W-1:0]));
         check("out_sin", 64'(out_sin), 64'(head[2*W-1:W]));
      end
   endtask

   task automatic model_step();
      bit was_full;
      int sat;
      sat = (1 << LW) - 1;
      if (!rst_n) begin
         q.delete();
         m_ovf = 0; m_frame = 0; m_done = 0; m_run = 0; m_len = 0;
      end else begin
         was_full = (q.size() == D);
         if (out_ready && q.size() != 0)
            void'(q.pop_front());
         if (valid_in && !was_full)
            q.push_back({sin_in, cos_in});
         if (valid_in && was_full)
            m_ovf = 1;
         else if (clr_ovf)
            m_ovf = 0;
         m_done = 0;
         if (valid_in) begin
            m_run   = m_frame ? ((m_run < sat) ? m_run + 1 : sat) : 1;
            m_frame = 1;
         end else if (m_frame) begin
            m_len   = m_run;
            m_done  = 1;
            m_frame = 0;
         end
      end
   endtask

   task automatic cycle(input bit v, input bit r, input bit c, input bit rs);
      @(negedge clk);
      check_outputs();
      valid_in  = v;
      out_ready = r;
      clr_ovf   = c;
      rst_n     = rs;
      cos_in    = W'($urandom);
      sin_in    = W'($urandom);
      @(posedge clk);
      model_step();
   endtask

   initial begin
      rst_n = 1'b0; valid_in = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      cos_in = '0; sin_in = '0;
      repeat (2) @(posedge clk);
      cycle(0, 0, 0, 1);

      // Long frame: fill, drop, saturate the length counter, then drain.
      repeat (40) cycle(1, 0, 0, 1);
      cycle(0, 0, 0, 1);
      repeat (10) cycle(0, 1, 0, 1);
      cycle(0, 0, 1, 1);

      // Two short frames separated by a single idle cycle.
      repeat (3) cycle(1, 0, 0, 1);
      cycle(0, 0, 0, 1);
      repeat (4) cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);
      repeat (8) cycle(0, 1, 0, 1);

      // Streaming write+read: pointers wrap repeatedly.
      repeat (50) cycle(1, 1, 0, 1);
      repeat (2) cycle(0, 1, 0, 1);

      // Beat at full with a read and clr_ovf in the same cycle.
      repeat (D) cycle(1, 0, 0, 1);
      cycle(1, 1, 1, 1);
      cycle(0, 0, 1, 1);
      repeat (D + 1) cycle(0, 1, 0, 1);

      // Random traffic.
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
               $urandom_range(0, 15) == 0, 1);
      repeat (D + 1) cycle(0, 1, 0, 1);

      // Reset in the middle of a frame with data buffered.
      repeat (5) cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 0);
      repeat (3) cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);
      repeat (4) cycle(0, 1, 0, 1);
      cycle(0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_result_collector.md
# cordic_result_collector

- Sink for the CORDIC pipeline output stream: takes each `valid_out` beat (`cos`, `sin`) into a circular buffer and returns the results to a host or checker over a ready/valid read port.
- Delimits frames on the falling edge of the pipeline's valid, reports frame length, and flags dropped samples.
- Sits between the CORDIC pipeline output and the result readout logic, giving an on-chip replacement for capturing results by file dump.

## Interface
Parameters:
- `WIDTH`, 16: bit width of `cos` and `sin`.
- `DEPTH`, 360: buffer entries; any value ≥ 2, need not be a power of two.
- `LEN_W`, 16: width of `frame_len`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `valid_in`  in  1  connects to the pipeline `valid_out`; a beat is any cycle with `valid_in`=1.
- `cos_in`  in  WIDTH  cosine result, sampled when `valid_in`=1.
- `sin_in`  in  WIDTH  sine result, sampled when `valid_in`=1.
- `out_valid`  out  1  buffer holds at least one entry.
- `out_ready`  in  1  host accepts the head entry.
- `out_cos`  out  WIDTH  head entry cosine.
- `out_sin`  out  WIDTH  head entry sine.
- `count`  out  $clog2(DEPTH+1)  occupied entries.
- `overflow`  out  1  sticky; set when a beat is dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `frame_len`  out  LEN_W  beats seen in the last completed frame.

## Operation
- Write: a beat with `count` < DEPTH stores at `wr_ptr`; `wr_ptr` advances. `wr_ptr` wraps from DEPTH-1 to 0.
- Full (`count`==DEPTH): the beat is dropped and `overflow` is set. A read in the same cycle does not rescue the beat, because fullness uses the registered `count`.
- Read: `out_valid`=(`count`!=0). `out_cos`/`out_sin` are the contents at `rd_ptr`, combinational from storage. A transfer is `out_valid`&&`out_ready`; `rd_ptr` advances with the same wrap as `wr_ptr`. `out_ready` while empty has no effect.
- Simultaneous accepted write and read: `count` is unchanged and both pointers advance.
- `overflow`:
  - set has priority over `clr_ovf` in the same cycle;
  - otherwise `clr_ovf` clears it.
- Frame FSM, states IDLE and CAPTURE:
  - IDLE→CAPTURE on `valid_in`=1. The beat counter loads 1 on this transition.
  - CAPTURE, `valid_in`=1: counter increments and saturates at 2^LEN_W−1. Both accepted and dropped beats count.
  - CAPTURE→IDLE on `valid_in`=0. `frame_len` is loaded from the counter and `frame_done` pulses, both registered on that edge.
  - `frame_len` holds until the next frame completes.
- Reset, including mid-frame or mid-readout:
  - all outputs and state go to their reset values: pointers 0, `count` 0, `out_valid` 0, `overflow` 0, `frame_done` 0, `frame_len` 0, state IDLE;
  - storage contents are not cleared;
  - a partial frame is discarded without a `frame_done` pulse.

## Timing
- Write-to-visible latency is 1 cycle. A beat at edge N gives `out_valid`=1 and the data on `out_cos`/`out_sin` after edge N; there is no same-cycle fall-through.
- The read port needs no wait states. With `out_ready` held high it sustains one entry per cycle.
- `count`, `overflow`, `frame_done` and `frame_len` are registered and update on the edge that causes them.
- `frame_done` is high for exactly the cycle after the last beat's edge.
- A single-cycle gap in `valid_in` ends the frame; the next beat starts a new frame.

## Structure
- Shared package `cordic_pkg` holds the frame FSM enum (`COLL_IDLE`, `COLL_CAPTURE`) and the default DEPTH/WIDTH constants; the CORDIC pipeline and this block use the same values from it.
- Sub-module `cordic_sample_fifo` is the circular buffer: storage, pointers, `count`, full/empty. It stores {sin, cos} concatenated, 2×WIDTH wide.
- The top level holds the frame FSM, the length counter and the `overflow` logic.

## Test plan
- 360 contiguous beats with `out_ready`=0 → `count`=360; `frame_done` pulses once, the cycle after the last beat; `frame_len`=360; `overflow`=0. Then `out_ready`=1 for 360 cycles drains the entries in order, and `out_valid` drops after the 360th.
- DEPTH=8, 10 contiguous beats with no reads → beats 9 and 10 dropped; `overflow`=1; `frame_len`=10. Readout returns beats 1–8. `clr_ovf` clears `overflow`, except in a cycle where a beat is also dropped.
- DEPTH=5 with continuous writes and reads → pointers wrap past 4 to 0 repeatedly; data order is preserved over 50 beats; `count` is constant.
- Beats at full with `out_ready`=1 in the same cycle → the beat is dropped, `overflow`=1 and `count` becomes DEPTH−1.
- Two frames of 3 and 4 beats separated by one idle cycle → two `frame_done` pulses; `frame_len` is 3, then 4.
- `rst_n` low for one cycle mid-frame, 5 beats in → `count`=0, `out_valid`=0, `overflow`=0, state IDLE, no `frame_done` pulse. The next beats start a new frame with `frame_len` counting from 1.
